// File: rtl/matvec_loader.sv
// matvec_loader: front end of the matrix-vector multiplier.
// Collects a byte stream into vector x, vector b and a 16x16 byte matrix,
// then releases the multiplier from reset and waits for it to finish.
module matvec_loader #(
  parameter int N  = 16,
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      A,
  output logic [N*DW-1:0] Q,
  output logic [N*DW-1:0] vector_x,
  output logic [N*DW-1:0] vector_b,
  input  logic            mv_finish,
  output logic            mv_rst,
  output logic            busy,
  output logic            done
);

  localparam int ROW_W = N * DW;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_X = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] LOAD_A = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [8:0]       cnt;
  logic [ROW_W-1:0] rows [N];
  logic             accept;
  logic             start_ok;
  logic [7:0]       a_off;
  logic             load_next;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state == IDLE || state == DONE);
  // Offset into the matrix section; the low 8 bits of c-32 are exact for c in 32..287.
  assign a_off    = cnt[7:0] - 8'd32;

  // Row read port for the multiplier, live in every state.
  assign Q = rows[A];

  // Next-state decode; section changes fire on the edge that takes the last byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_X;
      LOAD_X:  if (accept && cnt == 9'd15) state_next = LOAD_B;
      LOAD_B:  if (accept && cnt == 9'd31) state_next = LOAD_A;
      LOAD_A:  if (accept && cnt == 9'd287) state_next = RUN;
      RUN:     if (mv_finish) state_next = DONE;
      DONE:    if (start) state_next = LOAD_X;
      default: state_next = IDLE;
    endcase
  end

  assign load_next = (state_next == LOAD_X) || (state_next == LOAD_B) ||
                     (state_next == LOAD_A);

  // State, counter, registered status outputs and byte storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      vector_x <= '0;
      vector_b <= '0;
      for (int i = 0; i < N; i++) rows[i] <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mv_rst   <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= load_next;
      busy     <= load_next;
      done     <= (state_next == DONE);
      mv_rst   <= (state_next != RUN);

      if (start_ok) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 9'd1;
        case (state)
          LOAD_X:  vector_x[int'(cnt[3:0]) * DW +: DW] <= in_data;
          LOAD_B:  vector_b[int'(cnt[3:0]) * DW +: DW] <= in_data;
          LOAD_A:  rows[a_off[7:4]][int'(a_off[3:0]) * DW +: DW] <= in_data;
          default: ;
        endcase
      end
    end
  end

endmodule
